// File: rtl/fetch_module_if.sv
// Fetch-stage bus: decode redirects, program-load port and IF/ID outputs.
// IF_DEBUG_STEP_EN adds the i_step single-step qualifier.
interface fetch_module_if #(
   parameter int NB_BITS = 32,
   parameter int NB_JMP  = 28,
   parameter int NB_ADDR = 10
);
   logic [NB_BITS-1:0] i_brh_addr;
   logic [NB_JMP-1:0]  i_jmp_addr;
   logic               i_pc_src;
   logic               i_pc_beq;
   logic               i_flush;
   logic               i_stall;
   logic               i_load;
   logic [NB_ADDR-1:0] i_load_addr;
   logic [NB_BITS-1:0] i_load_data;
`ifdef IF_DEBUG_STEP_EN
   logic               i_step;
`endif
   logic [NB_BITS-1:0] o_if_id_pc;
   logic [NB_BITS-1:0] o_if_id_instr;
   logic               o_halt;

   modport master (
      output i_brh_addr, i_jmp_addr, i_pc_src, i_pc_beq,
      output i_flush, i_stall, i_load, i_load_addr, i_load_data,
`ifdef IF_DEBUG_STEP_EN
      output i_step,
`endif
      input  o_if_id_pc, o_if_id_instr, o_halt
   );

   modport slave (
      input  i_brh_addr, i_jmp_addr, i_pc_src, i_pc_beq,
      input  i_flush, i_stall, i_load, i_load_addr, i_load_data,
`ifdef IF_DEBUG_STEP_EN
      input  i_step,
`endif
      output o_if_id_pc, o_if_id_instr, o_halt
   );
endinterface

// File: rtl/fetch_module.sv
// MIPS IF stage: PC, synchronous-read instruction memory, IF/ID register.
// Define IF_DEBUG_STEP_EN to gate pipeline advance with bus.i_step.
module fetch_module #(
   parameter int                 NB_BITS   = 32,
   parameter int                 NB_JMP    = 28,
   parameter int                 NB_ADDR   = 10,
   parameter logic [NB_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input logic           i_clk,
   input logic           i_rst,
   fetch_module_if.slave bus
);
   logic [NB_BITS-1:0] mem [2**NB_ADDR];

   logic [NB_BITS-1:0] pc_q, pc_d;
   logic [NB_BITS-1:0] ifpc_q, ifpc_d;
   logic [NB_BITS-1:0] instr_q, instr_d;
   logic               halt_q, halt_d;

   logic [NB_BITS-1:0] pc4;
   logic [NB_BITS-1:0] jmp_tgt;
   logic [NB_BITS-1:0] next_pc;
   logic [NB_BITS-1:0] fetched;
   logic               adv;

   assign pc4     = pc_q + NB_BITS'(4);
   assign jmp_tgt = {pc4[NB_BITS-1:NB_JMP], bus.i_jmp_addr};
   assign fetched = mem[pc_q[NB_ADDR+1:2]];

`ifdef IF_DEBUG_STEP_EN
   assign adv = bus.i_step;
`else
   assign adv = 1'b1;
`endif

   always_comb begin
      next_pc = pc4;
      if (bus.i_pc_src)
         next_pc = bus.i_pc_beq ? bus.i_brh_addr : jmp_tgt;
   end

   // Priority: load > halt > flush > stall > normal fetch.
   always_comb begin
      pc_d    = pc_q;
      ifpc_d  = ifpc_q;
      instr_d = instr_q;
      halt_d  = halt_q;
      if (bus.i_load) begin
         pc_d = pc_q;
      end else if (halt_q) begin
         instr_d = '0;
      end else if (adv) begin
         if (bus.i_flush) begin
            pc_d    = next_pc;
            ifpc_d  = '0;
            instr_d = '0;
         end else if (!bus.i_stall) begin
            pc_d    = next_pc;
            ifpc_d  = pc4;
            instr_d = fetched;
            halt_d  = (fetched == HALT_WORD);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_q    <= '0;
         ifpc_q  <= '0;
         instr_q <= '0;
         halt_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ifpc_q  <= ifpc_d;
         instr_q <= instr_d;
         halt_q  <= halt_d;
      end
   end

   // Memory is not reset; a reset edge still blocks a pending load write.
   always_ff @(posedge i_clk) begin
      if (!i_rst && bus.i_load)
         mem[bus.i_load_addr] <= bus.i_load_data;
   end

   assign bus.o_if_id_pc    = ifpc_q;
   assign bus.o_if_id_instr = instr_q;
   assign bus.o_halt        = halt_q;
endmodule

// File: doc/fetch_module.md
Name: fetch_module

Overview:
- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline, directly upstream of Decode_module.
- Owns the PC register, a synchronous-read instruction memory and the IF/ID pipeline register.
- Supplies pc+4 and the instruction word to decode.
- Consumes decode's redirect signals: branch address, jump address, pc_src, pc_beq and flush.
- Also provides a program-load write port and halt detection.

Parameters:
- NB_BITS, 32, datapath/instruction width
- NB_JMP, 28, width of jump target from decode (26-bit index already shifted left by 2)
- NB_ADDR, 10, instruction memory word-address width (2^NB_ADDR words)
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_brh_addr  in  NB_BITS  branch / jr / jalr target from decode
- i_jmp_addr  in  NB_JMP  j / jal target from decode
- i_pc_src  in  1  1 = redirect PC this cycle
- i_pc_beq  in  1  redirect select: 1 = i_brh_addr, 0 = jump target
- i_flush  in  1  squash the IF/ID contents (insert NOP)
- i_stall  in  1  load-use hazard: hold PC and IF/ID
- i_load  in  1  program-load mode: write memory, pipeline frozen
- i_load_addr  in  NB_ADDR  word address for load
- i_load_data  in  NB_BITS  word to write
- o_if_id_pc  out  NB_BITS  pc+4 of the instruction in IF/ID
- o_if_id_instr  out  NB_BITS  instruction in IF/ID
- o_halt  out  1  sticky halt flag

Behaviour:
- Reset (i_rst=1 at edge): PC=0, o_if_id_pc=0, o_if_id_instr=0 (NOP), o_halt=0. Memory contents are not reset. Reset overrides every other input, including mid-load or mid-stall.
- pc4 = PC + 4, modulo 2^32.
- Jump target = {pc4[31:28], i_jmp_addr}, where pc4 is the IF-stage PC + 4.
- next_pc:
  - i_pc_src=1 and i_pc_beq=1: i_brh_addr
  - i_pc_src=1 and i_pc_beq=0: jump target
  - otherwise: pc4
- Memory index = PC[NB_ADDR+1:2]. PC[1:0] are ignored. Addresses beyond memory size wrap.
- Read is synchronous: word at PC appears on o_if_id_instr after the next rising edge, together with o_if_id_pc=pc4. One-cycle fetch latency.
- Per-edge priority, highest first:
  1. reset
  2. i_load: mem[i_load_addr] <= i_load_data; PC, IF/ID and o_halt held
  3. o_halt=1: PC held, o_if_id_instr <= 0, o_if_id_pc held
  4. i_flush: o_if_id_instr <= 0, o_if_id_pc <= 0, PC <= next_pc (the redirect is taken even if i_stall=1)
  5. i_stall: PC, o_if_id_pc and o_if_id_instr held
  6. normal: PC <= next_pc, IF/ID <= {pc4, mem word}
- Halt:
  - On a normal (unflushed, unstalled) edge where the fetched word equals HALT_WORD: o_if_id_instr <= HALT_WORD and o_halt <= 1 on the same edge.
  - PC has advanced by 4 on that edge; it then freezes.
  - The HALT word is passed to decode exactly once; NOPs follow.
  - A HALT word squashed by i_flush does not set o_halt.
  - o_halt clears only on reset.
- Load mode assumes the processor is otherwise idle. The block does not synchronise i_load with in-flight instructions.

Optional Feature:
- Macro: IF_DEBUG_STEP_EN.
- When defined:
  - Adds input i_step (1 bit).
  - Rules 4–6 take effect only on edges where i_step=1. Otherwise PC and IF/ID hold, exactly as in a stall.
  - Reset, load and halt behave as without the macro.
  - Allows the debug unit to single-step the pipeline.
- When undefined: no i_step port; the pipeline advances every edge, subject to the rules above.

Test Plan:
- Load mem[0..3]=32'h20010007, 32'h20020003, 32'h00221820, HALT; then release load and reset. Required: o_if_id_instr sequence 20010007, 20020003, 00221820, FFFFFFFF, then 0; o_if_id_pc sequence 4, 8, 12, 16; o_halt=1 from the HALT edge; PC frozen at 16.
- PC=8, i_pc_src=1, i_pc_beq=1, i_brh_addr=32'h40, i_flush=1 for one cycle. Required: o_if_id_instr=0 and o_if_id_pc=0 next cycle; following cycle o_if_id_pc=32'h44 and instruction = mem[16].
- PC=32'h0000_0010, i_pc_src=1, i_pc_beq=0, i_jmp_addr=28'h0000080. Required: PC becomes 32'h0000_0080.
- i_stall=1 for 2 cycles with IF/ID holding pc=12. Required: o_if_id_pc/o_if_id_instr unchanged for 2 cycles, then resume with pc=16. Same test with i_stall and i_flush both 1: flush wins.
- HALT at mem[2] with a redirect flush on the cycle it is fetched. Required: o_halt stays 0; fetch continues from the redirect target.
- Assert i_rst mid-run with o_halt=1. Required: all outputs 0; fetch restarts from PC=0.
